// File: rtl/id_pkg.sv
// Shared opcode map, instruction field positions and control-bundle types
// for the ID stage and its combinational decoder.
package id_pkg;

   localparam int OPC_HI  = 31;
   localparam int OPC_LO  = 25;
   localparam int S_BIT   = 28;
   localparam int ALU_HI  = 27;
   localparam int ALU_LO  = 25;
   localparam int RD_LO   = 22;
   localparam int RS1_LO  = 19;
   localparam int RS2_LO  = 16;
   localparam int COND_HI = 24;
   localparam int COND_LO = 21;

   localparam logic [6:0] OPC_LOAD  = 7'b1000000;
   localparam logic [6:0] OPC_STOR  = 7'b1000001;
   localparam logic [6:0] OPC_MOV   = 7'b0000000;
   localparam logic [6:0] OPC_MOVT  = 7'b0000001;
   localparam logic [6:0] OPC_LSL   = 7'b0000100;
   localparam logic [6:0] OPC_LSR   = 7'b0000101;
   localparam logic [6:0] OPC_CLR   = 7'b0000010;
   localparam logic [6:0] OPC_SET   = 7'b0000011;
   localparam logic [6:0] OPC_NOT   = 7'b0110110;
   localparam logic [6:0] OPC_B     = 7'b1100000;
   localparam logic [6:0] OPC_BCOND = 7'b1100001;
   localparam logic [6:0] OPC_BR    = 7'b1100010;
   localparam logic [6:0] OPC_NOP   = 7'b1100100;
   localparam logic [6:0] OPC_HALT  = 7'b1101000;

   // ALU classes are identified by opcode bits [6:4]; bit 3 is the S flag.
   localparam logic [2:0] ALU_CLS_IMM = 3'b001;
   localparam logic [2:0] ALU_CLS_REG = 3'b011;

   typedef enum logic [1:0] {
      WB_ALU   = 2'd0,
      WB_MEM   = 2'd1,
      WB_IMM   = 2'd2,
      WB_MERGE = 2'd3
   } wb_sel_e;

   typedef enum logic [2:0] {
      ALU_ADD = 3'd0,
      ALU_SUB = 3'd1,
      ALU_AND = 3'd2,
      ALU_OR  = 3'd3,
      ALU_XOR = 3'd4,
      ALU_LSL = 3'd5,
      ALU_NOT = 3'd6,
      ALU_LSR = 3'd7
   } alu_op_e;

   typedef enum logic [1:0] {
      IMM_ZEXT = 2'd0,
      IMM_ONES = 2'd1,
      IMM_ZERO = 2'd2
   } imm_mode_e;

   typedef struct packed {
      alu_op_e    alu_op;
      logic       use_imm;
      logic       reg_we;
      logic       flags_we;
      logic       mem_rd;
      logic       mem_wr;
      wb_sel_e    wb_sel;
      logic       merge_hi;
      logic       bcond;
      logic [3:0] cond;
      logic       halt;
   } ctrl_t;

   function automatic logic is_alu_class(input logic [6:0] opc);
      return (opc[6:4] == ALU_CLS_IMM) || (opc[6:4] == ALU_CLS_REG);
   endfunction

endpackage

// File: rtl/id_decode_comb.sv
// Pure combinational opcode decoder: instruction word to control bundle,
// register indices, immediate and the mask of source fields actually read.
module id_decode_comb
   import id_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int RAW   = 3,
   parameter int IMM_W = 16
) (
   input  logic [31:0]     instr,
   output ctrl_t           ctrl,
   output logic [XLEN-1:0] imm,
   output logic [RAW-1:0]  rd,
   output logic [RAW-1:0]  rs1,
   output logic [RAW-1:0]  rs2,
   output logic [RAW-1:0]  fld_rd,
   output logic [RAW-1:0]  fld_rs1,
   output logic [RAW-1:0]  fld_rs2,
   output logic            use_rd,
   output logic            use_rs1,
   output logic            use_rs2,
   output logic            illegal
);

   logic [6:0] opc;
   imm_mode_e  imm_mode;

   assign opc     = instr[OPC_HI:OPC_LO];
   assign fld_rd  = instr[RD_LO  +: RAW];
   assign fld_rs1 = instr[RS1_LO +: RAW];
   assign fld_rs2 = instr[RS2_LO +: RAW];

   always_comb begin
      ctrl        = '0;
      ctrl.alu_op = alu_op_e'(instr[ALU_HI:ALU_LO]);
      ctrl.wb_sel = WB_ALU;
      imm_mode    = IMM_ZEXT;
      use_rd      = 1'b0;
      use_rs1     = 1'b0;
      use_rs2     = 1'b0;
      illegal     = 1'b0;
      if (is_alu_class(opc)) begin
         ctrl.reg_we   = 1'b1;
         ctrl.flags_we = instr[S_BIT];
         use_rs1       = 1'b1;
         if (opc[6:4] == ALU_CLS_IMM) begin
            ctrl.use_imm = 1'b1;
         end else begin
            // NOT is a register-class op with a single operand.
            use_rs2 = (opc != OPC_NOT);
         end
      end else begin
         case (opc)
            OPC_LSL, OPC_LSR: begin
               ctrl.reg_we  = 1'b1;
               ctrl.use_imm = 1'b1;
               ctrl.alu_op  = (opc == OPC_LSL) ? ALU_LSL : ALU_LSR;
               use_rs1      = 1'b1;
            end
            OPC_MOV, OPC_MOVT: begin
               ctrl.reg_we   = 1'b1;
               ctrl.wb_sel   = WB_MERGE;
               ctrl.merge_hi = (opc == OPC_MOVT);
               use_rd        = 1'b1;
            end
            OPC_CLR, OPC_SET: begin
               ctrl.reg_we = 1'b1;
               ctrl.wb_sel = WB_IMM;
               imm_mode    = (opc == OPC_SET) ? IMM_ONES : IMM_ZERO;
            end
            OPC_LOAD: begin
               ctrl.reg_we  = 1'b1;
               ctrl.mem_rd  = 1'b1;
               ctrl.wb_sel  = WB_MEM;
               ctrl.use_imm = 1'b1;
               use_rs1      = 1'b1;
            end
            OPC_STOR: begin
               ctrl.mem_wr  = 1'b1;
               ctrl.use_imm = 1'b1;
               use_rs1      = 1'b1;
               use_rd       = 1'b1;
            end
            OPC_BCOND: begin
               ctrl.bcond = 1'b1;
               ctrl.cond  = instr[COND_HI:COND_LO];
            end
            OPC_NOP: begin
            end
            OPC_HALT: begin
               ctrl.halt = 1'b1;
            end
            default: begin
               illegal = 1'b1;
            end
         endcase
      end
   end

   always_comb begin
      case (imm_mode)
         IMM_ONES: imm = '1;
         IMM_ZERO: imm = '0;
         default:  imm = XLEN'(instr[IMM_W-1:0]);
      endcase
   end

   // STOR carries its data register in the rd field; it lands on rs2.
   assign rd  = ctrl.reg_we ? fld_rd : '0;
   assign rs1 = (use_rd && !ctrl.mem_wr) ? fld_rd : (use_rs1 ? fld_rs1 : '0);
   assign rs2 = use_rs2 ? fld_rs2 : (ctrl.mem_wr ? fld_rd : '0);

endmodule

// File: rtl/id_stage_pipe.sv
// Pipelined ID stage: IF/EX valid-ready handshake, load-use interlock,
// flush, HALT latching, illegal-opcode pulse and the ID/EX register.
module id_stage_pipe
   import id_pkg::*;
#(
   parameter int  XLEN  = 32,
   parameter int  NREGS = 8,
   parameter int  IMM_W = 16,
   localparam int RAW   = $clog2(NREGS)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            if_valid,
   input  logic [31:0]     if_instr,
   output logic            id_ready,
   input  logic            flush,
   output logic [RAW-1:0]  rf_raddr1,
   output logic [RAW-1:0]  rf_raddr2,
   output logic            ex_valid,
   input  logic            ex_ready,
   output logic [2:0]      ex_alu_op,
   output logic [RAW-1:0]  ex_rd,
   output logic [RAW-1:0]  ex_rs1,
   output logic [RAW-1:0]  ex_rs2,
   output logic [XLEN-1:0] ex_imm,
   output logic            ex_use_imm,
   output logic            ex_reg_we,
   output logic            ex_flags_we,
   output logic            ex_mem_rd,
   output logic            ex_mem_wr,
   output logic [1:0]      ex_wb_sel,
   output logic            ex_merge_hi,
   output logic            ex_bcond,
   output logic [3:0]      ex_cond,
   output logic            ex_halt,
   output logic            halted,
   output logic            illegal
);

   if (RAW < 1 || RAW > 3) begin : g_bad_nregs
      $error("id_stage_pipe: NREGS must give a register index of 1..3 bits");
   end

   ctrl_t           dec_ctrl;
   logic [XLEN-1:0] dec_imm;
   logic [RAW-1:0]  dec_rd, dec_rs1, dec_rs2;
   logic [RAW-1:0]  fld_rd, fld_rs1, fld_rs2;
   logic            use_rd, use_rs1, use_rs2;
   logic            dec_illegal;

   ctrl_t           ctrl_p1;
   logic [XLEN-1:0] imm_p1;
   logic [RAW-1:0]  rd_p1, rs1_p1, rs2_p1;
   logic            vld_p1;
   logic            halted_q;
   logic            illegal_q;

   logic            src_hit;
   logic            stall;
   logic            accept;

   id_decode_comb #(
      .XLEN  (XLEN),
      .RAW   (RAW),
      .IMM_W (IMM_W)
   ) u_decode (
      .instr   (if_instr),
      .ctrl    (dec_ctrl),
      .imm     (dec_imm),
      .rd      (dec_rd),
      .rs1     (dec_rs1),
      .rs2     (dec_rs2),
      .fld_rd  (fld_rd),
      .fld_rs1 (fld_rs1),
      .fld_rs2 (fld_rs2),
      .use_rd  (use_rd),
      .use_rs1 (use_rs1),
      .use_rs2 (use_rs2),
      .illegal (dec_illegal)
   );

   assign rf_raddr1 = use_rd ? fld_rd : fld_rs1;
   assign rf_raddr2 = fld_rs2;

   // Load-use hazard: the load in EX writes a register the incoming op reads.
   assign src_hit = (use_rs1 && (fld_rs1 == rd_p1)) ||
                    (use_rs2 && (fld_rs2 == rd_p1)) ||
                    (use_rd  && (fld_rd  == rd_p1));
   assign stall    = if_valid && vld_p1 && ctrl_p1.mem_rd && src_hit;
   assign id_ready = !halted_q && !flush && !stall && (!vld_p1 || ex_ready);
   assign accept   = if_valid && id_ready;

   // ---- ID/EX pipeline register ----
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_p1    <= 1'b0;
         halted_q  <= 1'b0;
         illegal_q <= 1'b0;
         ctrl_p1   <= '0;
         imm_p1    <= '0;
         rd_p1     <= '0;
         rs1_p1    <= '0;
         rs2_p1    <= '0;
      end else begin
         illegal_q <= accept && dec_illegal;
         if (accept && dec_ctrl.halt) begin
            halted_q <= 1'b1;
         end
         if (flush) begin
            vld_p1 <= 1'b0;
         end else if (accept) begin
            vld_p1 <= !dec_illegal;
         end else if (ex_ready) begin
            vld_p1 <= 1'b0;
         end
         if (accept && !dec_illegal) begin
            ctrl_p1 <= dec_ctrl;
            imm_p1  <= dec_imm;
            rd_p1   <= dec_rd;
            rs1_p1  <= dec_rs1;
            rs2_p1  <= dec_rs2;
         end
      end
   end

   assign ex_valid    = vld_p1;
   assign ex_alu_op   = ctrl_p1.alu_op;
   assign ex_rd       = rd_p1;
   assign ex_rs1      = rs1_p1;
   assign ex_rs2      = rs2_p1;
   assign ex_imm      = imm_p1;
   assign ex_use_imm  = ctrl_p1.use_imm;
   assign ex_reg_we   = ctrl_p1.reg_we;
   assign ex_flags_we = ctrl_p1.flags_we;
   assign ex_mem_rd   = ctrl_p1.mem_rd;
   assign ex_mem_wr   = ctrl_p1.mem_wr;
   assign ex_wb_sel   = ctrl_p1.wb_sel;
   assign ex_merge_hi = ctrl_p1.merge_hi;
   assign ex_bcond    = ctrl_p1.bcond;
   assign ex_cond     = ctrl_p1.cond;
   assign ex_halt     = ctrl_p1.halt;
   assign halted      = halted_q;
   assign illegal     = illegal_q;

endmodule

// File: tb/tb_id_stage_pipe.sv
// Directed bench for id_stage_pipe with a scoreboard of expected EX bundles.
module tb_id_stage_pipe;

   logic        clk;
   logic        rst_n;
   logic        if_valid;
   logic [31:0] if_instr;
   logic        id_ready;
   logic        flush;
   logic [2:0]  rf_raddr1, rf_raddr2;
   logic        ex_valid;
   logic        ex_ready;
   logic [2:0]  ex_alu_op;
   logic [2:0]  ex_rd, ex_rs1, ex_rs2;
   logic [31:0] ex_imm;
   logic        ex_use_imm, ex_reg_we, ex_flags_we, ex_mem_rd, ex_mem_wr;
   logic [1:0]  ex_wb_sel;
   logic        ex_merge_hi, ex_bcond;
   logic [3:0]  ex_cond;
   logic        ex_halt, halted, illegal;

   typedef struct packed {
      logic [2:0]  alu;
      logic [2:0]  rd;
      logic [2:0]  rs1;
      logic [2:0]  rs2;
      logic [31:0] imm;
      logic        use_imm;
      logic        reg_we;
      logic        flags_we;
      logic        mem_rd;
      logic        mem_wr;
      logic [1:0]  wb;
      logic        merge_hi;
      logic        bcond;
      logic [3:0]  cond;
      logic        halt;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   passed = 0;
   int   w;
   logic vs;

   id_stage_pipe dut (
      .clk(clk), .rst_n(rst_n), .if_valid(if_valid), .if_instr(if_instr),
      .id_ready(id_ready), .flush(flush), .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
      .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_alu_op(ex_alu_op),
      .ex_rd(ex_rd), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_imm(ex_imm),
      .ex_use_imm(ex_use_imm), .ex_reg_we(ex_reg_we), .ex_flags_we(ex_flags_we),
      .ex_mem_rd(ex_mem_rd), .ex_mem_wr(ex_mem_wr), .ex_wb_sel(ex_wb_sel),
      .ex_merge_hi(ex_merge_hi), .ex_bcond(ex_bcond), .ex_cond(ex_cond),
      .ex_halt(ex_halt), .halted(halted), .illegal(illegal)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   function automatic logic [31:0] mk(input logic [6:0] o, input logic [2:0] d,
                                      input logic [2:0] a, input logic [2:0] b,
                                      input logic [15:0] im);
      return {o, d, a, b, im};
   endfunction

   function automatic exp_t model(input logic [31:0] ins, output logic ill);
      exp_t e;
      logic [6:0] o;
      logic [2:0] frd, frs1, frs2;
      o    = ins[31:25];
      frd  = ins[24:22];
      frs1 = ins[21:19];
      frs2 = ins[18:16];
      e     = '0;
      e.alu = o[2:0];
      e.imm = {16'h0000, ins[15:0]};
      ill   = 1'b0;
      if (o[6:4] == 3'b001) begin
         e.rd = frd; e.rs1 = frs1; e.use_imm = 1'b1; e.reg_we = 1'b1; e.flags_we = o[3];
      end else if (o[6:4] == 3'b011) begin
         e.rd = frd; e.rs1 = frs1; e.reg_we = 1'b1; e.flags_we = o[3];
         e.rs2 = (o == 7'b0110110) ? 3'd0 : frs2;
      end else begin
         case (o)
            7'b0000100, 7'b0000101: begin
               e.alu = (o[0]) ? 3'd7 : 3'd5;
               e.rd = frd; e.rs1 = frs1; e.use_imm = 1'b1; e.reg_we = 1'b1;
            end
            7'b0000000, 7'b0000001: begin
               e.rd = frd; e.rs1 = frd; e.reg_we = 1'b1; e.wb = 2'd3; e.merge_hi = o[0];
            end
            7'b0000010, 7'b0000011: begin
               e.rd = frd; e.reg_we = 1'b1; e.wb = 2'd2;
               e.imm = o[0] ? 32'hFFFF_FFFF : 32'h0;
            end
            7'b1000000: begin
               e.rd = frd; e.rs1 = frs1; e.use_imm = 1'b1; e.reg_we = 1'b1;
               e.mem_rd = 1'b1; e.wb = 2'd1;
            end
            7'b1000001: begin
               e.rs1 = frs1; e.rs2 = frd; e.use_imm = 1'b1; e.mem_wr = 1'b1;
            end
            7'b1100001: begin
               e.bcond = 1'b1; e.cond = ins[24:21];
            end
            7'b1100100: begin
            end
            7'b1101000: e.halt = 1'b1;
            default:    ill = 1'b1;
         endcase
      end
      return e;
   endfunction

   function automatic exp_t dut_bundle();
      exp_t g;
      g.alu = ex_alu_op; g.rd = ex_rd; g.rs1 = ex_rs1; g.rs2 = ex_rs2; g.imm = ex_imm;
      g.use_imm = ex_use_imm; g.reg_we = ex_reg_we; g.flags_we = ex_flags_we;
      g.mem_rd = ex_mem_rd; g.mem_wr = ex_mem_wr; g.wb = ex_wb_sel;
      g.merge_hi = ex_merge_hi; g.bcond = ex_bcond; g.cond = ex_cond; g.halt = ex_halt;
      return g;
   endfunction

   // Every bundle EX consumes must match the oldest expected entry.
   always @(negedge clk) begin
      if (rst_n && ex_valid && ex_ready) begin
         if (sb.size() == 0) begin
            chk("unexpected bundle", 64'(ex_valid), 64'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("bundle", 64'(dut_bundle()), 64'(e));
         end
      end
   end

   // Present ins until accepted; waits = cycles id_ready stayed low.
   task automatic issue(input logic [31:0] ins, output int waits, output logic vld_seen);
      logic acc;
      logic ill;
      exp_t e;
      if_instr = ins;
      if_valid = 1'b1;
      waits    = 0;
      acc      = 1'b0;
      vld_seen = 1'b0;
      for (int i = 0; i < 20 && !acc; i++) begin
         @(negedge clk);
         if (id_ready) begin
            acc      = 1'b1;
            vld_seen = ex_valid;
         end else begin
            waits++;
         end
      end
      chk("accept within budget", 64'(acc), 64'd1);
      e = model(ins, ill);
      if (acc && !ill) sb.push_back(e);
      @(posedge clk);
      #1;
   endtask

   task automatic idle_cycle();
      if_valid = 1'b0;
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0; if_valid = 1'b0; if_instr = '0; flush = 1'b0; ex_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      chk("reset ex_valid", 64'(ex_valid), 64'd0);
      chk("reset halted", 64'(halted), 64'd0);
      chk("reset illegal", 64'(illegal), 64'd0);
      chk("reset ex_imm", 64'(ex_imm), 64'd0);
      chk("reset ex_rd", 64'(ex_rd), 64'd0);
      chk("reset id_ready", 64'(id_ready), 64'd1);
      @(posedge clk); #1;

      // ADD r1,r2,#5 then SUBS r3,r1,r4 back to back
      issue(mk(7'b0010000, 3'd1, 3'd2, 3'd0, 16'd5), w, vs);
      issue(mk(7'b0111001, 3'd3, 3'd1, 3'd4, 16'd0), w, vs);
      chk("subs no wait", 64'(w), 64'd0);
      chk("subs back-to-back", 64'(vs), 64'd1);
      chk("subs raddr1", 64'(rf_raddr1), 64'd1);
      chk("subs raddr2", 64'(rf_raddr2), 64'd4);

      // LOAD r2,[r1,#8] then dependent ADD r3,r2,r5: one bubble
      issue(mk(7'b1000000, 3'd2, 3'd1, 3'd0, 16'd8), w, vs);
      issue(mk(7'b0110000, 3'd3, 3'd2, 3'd5, 16'd0), w, vs);
      chk("load-use stall cycles", 64'(w), 64'd1);
      chk("load-use bubble", 64'(vs), 64'd0);
      // LOAD then independent op: no stall
      issue(mk(7'b1000000, 3'd2, 3'd1, 3'd0, 16'd12), w, vs);
      issue(mk(7'b0010000, 3'd4, 3'd6, 3'd2, 16'd1), w, vs);
      chk("load no-dep wait", 64'(w), 64'd0);
      // LOAD r3 then STOR with r3 as data: stalls on the rd-field source
      issue(mk(7'b1000000, 3'd3, 3'd0, 3'd0, 16'd4), w, vs);
      issue(mk(7'b1000001, 3'd3, 3'd1, 3'd0, 16'h20), w, vs);
      chk("stor data stall", 64'(w), 64'd1);
      chk("stor raddr1 uses rd", 64'(rf_raddr1), 64'd3);

      // Decode coverage stream
      issue(mk(7'b0110110, 3'd1, 3'd2, 3'd7, 16'd0), w, vs);
      issue(mk(7'b0000100, 3'd2, 3'd3, 3'd0, 16'd4), w, vs);
      issue(mk(7'b0000101, 3'd2, 3'd2, 3'd0, 16'd1), w, vs);
      issue(mk(7'b0000010, 3'd4, 3'd0, 3'd0, 16'h1234), w, vs);
      issue(mk(7'b0000011, 3'd5, 3'd0, 3'd0, 16'h0000), w, vs);
      issue(mk(7'b0011101, 3'd6, 3'd5, 3'd0, 16'h00FF), w, vs);
      issue(mk(7'b1100001, 3'd5, 3'd4, 3'd0, 16'h0040), w, vs);
      issue(mk(7'b1100100, 3'd0, 3'd0, 3'd0, 16'd0), w, vs);
      idle_cycle();
      idle_cycle();

      // MOVT r6,#0xBEEF held by EX backpressure for 3 cycles
      ex_ready = 1'b0;
      issue(mk(7'b0000001, 3'd6, 3'd0, 3'd0, 16'hBEEF), w, vs);
      if_instr = mk(7'b1100100, 3'd0, 3'd0, 3'd0, 16'd0);
      if_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("hold ex_valid", 64'(ex_valid), 64'd1);
         chk("hold ex_imm", 64'(ex_imm), 64'h0000_BEEF);
         chk("hold merge_hi", 64'(ex_merge_hi), 64'd1);
         chk("hold id_ready", 64'(id_ready), 64'd0);
         @(posedge clk); #1;
      end
      ex_ready = 1'b1;
      issue(mk(7'b1100100, 3'd0, 3'd0, 3'd0, 16'd0), w, vs);
      chk("release wait", 64'(w), 64'd0);
      idle_cycle();
      idle_cycle();

      // flush kills a held bundle and drops the incoming instruction
      ex_ready = 1'b0;
      issue(mk(7'b0010000, 3'd5, 3'd1, 3'd0, 16'd3), w, vs);
      flush    = 1'b1;
      if_instr = mk(7'b0010000, 3'd6, 3'd1, 3'd0, 16'd7);
      if_valid = 1'b1;
      @(negedge clk);
      chk("flush id_ready", 64'(id_ready), 64'd0);
      @(posedge clk); #1;
      flush = 1'b0; if_valid = 1'b0;
      @(negedge clk);
      chk("flush clears ex_valid", 64'(ex_valid), 64'd0);
      void'(sb.pop_back());
      ex_ready = 1'b1;
      @(posedge clk); #1;

      // flush together with HALT: HALT not accepted
      flush    = 1'b1;
      if_instr = mk(7'b1101000, 3'd0, 3'd0, 3'd0, 16'd0);
      if_valid = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0; if_valid = 1'b0;
      @(negedge clk);
      chk("flushed halt halted", 64'(halted), 64'd0);
      chk("flushed halt ex_valid", 64'(ex_valid), 64'd0);
      @(posedge clk); #1;

      // illegal opcodes: 1111111, B, BR
      for (int k = 0; k < 3; k++) begin
         logic [6:0] opc_tab [3];
         opc_tab[0] = 7'b1111111; opc_tab[1] = 7'b1100000; opc_tab[2] = 7'b1100010;
         issue(mk(opc_tab[k], 3'd1, 3'd2, 3'd3, 16'd9), w, vs);
         if_valid = 1'b0;
         @(negedge clk);
         chk("illegal pulse", 64'(illegal), 64'd1);
         chk("illegal no bundle", 64'(ex_valid), 64'd0);
         @(negedge clk);
         chk("illegal one cycle", 64'(illegal), 64'd0);
         @(posedge clk); #1;
      end

      // HALT then NOP: NOP never accepted, flush leaves halted set
      issue(mk(7'b1101000, 3'd0, 3'd0, 3'd0, 16'd0), w, vs);
      if_instr = mk(7'b1100100, 3'd0, 3'd0, 3'd0, 16'd0);
      if_valid = 1'b1;
      @(negedge clk);
      chk("halt bundle ex_halt", 64'(ex_halt), 64'd1);
      chk("halted set", 64'(halted), 64'd1);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("halted id_ready", 64'(id_ready), 64'd0);
         chk("halted no bundle", 64'(ex_valid), 64'd0);
      end
      @(posedge clk); #1;
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      @(negedge clk);
      chk("flush keeps halted", 64'(halted), 64'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("async reset halted", 64'(halted), 64'd0);
      if_valid = 1'b0;
      sb.delete();
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      // async reset while a stalled LOAD is held
      issue(mk(7'b1000000, 3'd2, 3'd1, 3'd0, 16'd8), w, vs);
      ex_ready = 1'b0;
      if_instr = mk(7'b0110000, 3'd3, 3'd2, 3'd5, 16'd0);
      if_valid = 1'b1;
      @(negedge clk);
      chk("held load ex_valid", 64'(ex_valid), 64'd1);
      chk("held load id_ready", 64'(id_ready), 64'd0);
      #2 rst_n = 1'b0;
      #1;
      chk("async reset ex_valid", 64'(ex_valid), 64'd0);
      chk("async reset ex_mem_rd", 64'(ex_mem_rd), 64'd0);
      chk("async reset ex_rd", 64'(ex_rd), 64'd0);
      sb.delete();
      if_valid = 1'b0;
      ex_ready = 1'b1;
      @(posedge clk); #1;
      rst_n = 1'b1;
      idle_cycle();

      chk("scoreboard drained", 64'(sb.size()), 64'd0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
